// File: rtl/knn_pkg.sv
// Shared types and width helpers for the KNN training-set feeder.
package knn_pkg;

  // Feeder control states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SERVE,
    ST_FETCH,
    ST_PRESENT
  } state_e;

  // Default geometry; instances override through module parameters
  localparam int DEF_M            = 4;
  localparam int DEF_N            = 4;
  localparam int DEF_W            = 8;
  localparam int DEF_MAX_ELEMENTS = 16;

  localparam int SAMPLE_W = DEF_W * DEF_M * DEF_N;
  localparam int CW       = $clog2(DEF_MAX_ELEMENTS + 1);

  // Flattened sample width for a given geometry
  function automatic int sample_width(input int w, input int m, input int n);
    return w * m * n;
  endfunction

  // Width able to hold a count of 0..max_el
  function automatic int count_width(input int max_el);
    return $clog2(max_el + 1);
  endfunction

endpackage

// File: rtl/knn_data_feeder_if.sv
// Load / serve bus between the KNN system and the training-set feeder.
interface knn_data_feeder_if #(
  parameter int SAMPLE_W = 128,
  parameter int TYPE_W   = 2,
  parameter int CW       = 5
);
  logic                wr_valid;
  logic                wr_ready;
  logic [SAMPLE_W-1:0] wr_data;
  logic [TYPE_W-1:0]   wr_type;
  logic                wr_last;
  logic                in_valid;
  logic [SAMPLE_W-1:0] in_data;
  logic                clear;
  logic                data_request;
  logic                read_done;
  logic [SAMPLE_W-1:0] training_data;
  logic [TYPE_W-1:0]   training_data_type;
  logic [SAMPLE_W-1:0] input_data;
  logic [CW-1:0]       sample_count;
  logic                exhausted;
  logic                req_overflow;

  modport master (
    output wr_valid, wr_data, wr_type, wr_last, in_valid, in_data, clear, data_request,
    input  wr_ready, read_done, training_data, training_data_type, input_data,
           sample_count, exhausted, req_overflow
  );

  modport slave (
    input  wr_valid, wr_data, wr_type, wr_last, in_valid, in_data, clear, data_request,
    output wr_ready, read_done, training_data, training_data_type, input_data,
           sample_count, exhausted, req_overflow
  );
endinterface

// File: rtl/knn_sample_mem.sv
// Training-sample store: one write port, one synchronous read port, no array reset.
module knn_sample_mem #(
  parameter int DEPTH = 16,
  parameter int DW    = 130,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/knn_data_feeder.sv
// Loads a labelled training set plus a query sample, then presents one
// training sample per data_request with a one-cycle read_done pulse.
module knn_data_feeder
  import knn_pkg::*;
#(
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int W            = 8,
  parameter int MAX_ELEMENTS = 16,
  parameter int TYPE_W       = 2,
  parameter bit WRAP         = 1'b0
) (
  input logic              clk,
  input logic              rst,
  knn_data_feeder_if.slave bus
);
  localparam int SW   = sample_width(W, M, N);
  localparam int CNTW = count_width(MAX_ELEMENTS);
  localparam int AW   = (MAX_ELEMENTS > 1) ? $clog2(MAX_ELEMENTS) : 1;
  localparam logic [CNTW-1:0] MAX_C = CNTW'(MAX_ELEMENTS);

  state_e              state_q, state_d;
  logic [CNTW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic                pend_q, pend_d;
  logic                exh_q, exh_d;
  logic                ovf_q, ovf_d;
  logic [SW-1:0]       tdata_q;
  logic [TYPE_W-1:0]   ttype_q;
  logic [SW-1:0]       qdata_q;
  logic [TYPE_W+SW-1:0] mem_rdata;
  logic                wr_en, rd_en, presenting;

  assign bus.wr_ready = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && (wr_ptr_q < MAX_C);
  assign wr_en        = bus.wr_valid && bus.wr_ready && !bus.clear;
  assign rd_en        = (state_q == ST_FETCH);
  assign presenting   = (state_q == ST_PRESENT);

  knn_sample_mem #(
    .DEPTH (MAX_ELEMENTS),
    .DW    (TYPE_W + SW),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({bus.wr_type, bus.wr_data}),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // Next-state logic: load sequencing, request serving and sticky flags
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pend_d   = pend_q;
    exh_d    = exh_q;
    ovf_d    = ovf_q;
    if (bus.clear) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pend_d   = 1'b0;
      exh_d    = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (bus.wr_last) begin
              count_d = wr_ptr_q + 1'b1;
              state_d = ST_SERVE;
            end else begin
              state_d = ST_LOAD;
            end
          end else if ((state_q == ST_LOAD) && (wr_ptr_q == MAX_C)) begin
            // Capacity reached without wr_last: close the set
            count_d = MAX_C;
            state_d = ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (bus.data_request) begin
            if (rd_ptr_q == count_q) begin
              if (WRAP) begin
                rd_ptr_d = '0;
                state_d  = ST_FETCH;
              end else begin
                exh_d = 1'b1;
              end
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (bus.data_request) begin
            if (pend_q) ovf_d = 1'b1;
            else        pend_d = 1'b1;
          end
          state_d = ST_PRESENT;
        end
        ST_PRESENT: begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          pend_d   = 1'b0;
          if (pend_q && bus.data_request) ovf_d = 1'b1;
          if (pend_q || bus.data_request) begin
            // Serve the pending request, applying the end-of-set rule
            if ((rd_ptr_q + 1'b1) == count_q) begin
              if (WRAP) begin
                rd_ptr_d = '0;
                state_d  = ST_FETCH;
              end else begin
                exh_d   = 1'b1;
                state_d = ST_SERVE;
              end
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            state_d = ST_SERVE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      exh_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      exh_q    <= exh_d;
      ovf_q    <= ovf_d;
    end
  end

  // Held copies of the presented sample and the query sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tdata_q <= '0;
      ttype_q <= '0;
      qdata_q <= '0;
    end else begin
      if (presenting) begin
        tdata_q <= mem_rdata[SW-1:0];
        ttype_q <= mem_rdata[TYPE_W+SW-1:SW];
      end
      if (bus.in_valid) qdata_q <= bus.in_data;
    end
  end

  // During PRESENT the RAM output is shown directly; afterwards the held copy
  assign bus.read_done          = presenting;
  assign bus.training_data      = presenting ? mem_rdata[SW-1:0] : tdata_q;
  assign bus.training_data_type = presenting ? mem_rdata[TYPE_W+SW-1:SW] : ttype_q;
  assign bus.input_data         = qdata_q;
  assign bus.sample_count       = count_q;
  assign bus.exhausted          = exh_q;
  assign bus.req_overflow       = ovf_q;
endmodule

// File: tb/tb_knn_data_feeder.sv
// Directed bench for knn_data_feeder: a WRAP=0 and a WRAP=1 instance share stimulus.
module tb_knn_data_feeder;
  import knn_pkg::*;

  localparam int SW = 32;
  localparam int TW = 2;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_valid, wr_last, in_valid, clear, data_request;
  logic [SW-1:0] wr_data, in_data;
  logic [TW-1:0] wr_type;

  knn_data_feeder_if #(.SAMPLE_W(SW), .TYPE_W(TW), .CW(CW)) bus0 ();
  knn_data_feeder_if #(.SAMPLE_W(SW), .TYPE_W(TW), .CW(CW)) bus1 ();

  assign bus0.wr_valid = wr_valid;     assign bus1.wr_valid = wr_valid;
  assign bus0.wr_data = wr_data;       assign bus1.wr_data = wr_data;
  assign bus0.wr_type = wr_type;       assign bus1.wr_type = wr_type;
  assign bus0.wr_last = wr_last;       assign bus1.wr_last = wr_last;
  assign bus0.in_valid = in_valid;     assign bus1.in_valid = in_valid;
  assign bus0.in_data = in_data;       assign bus1.in_data = in_data;
  assign bus0.clear = clear;           assign bus1.clear = clear;
  assign bus0.data_request = data_request;
  assign bus1.data_request = data_request;

  knn_data_feeder #(.M(2), .N(2), .W(8), .MAX_ELEMENTS(4), .TYPE_W(2), .WRAP(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  knn_data_feeder #(.M(2), .N(2), .W(8), .MAX_ELEMENTS(4), .TYPE_W(2), .WRAP(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [SW-1:0] data;
    logic [TW-1:0] typ;
    logic          last;
  } wvec_t;

  typedef struct {
    logic          done0;
    logic [SW-1:0] data0;
    logic [TW-1:0] typ0;
    logic          done1;
    logic [SW-1:0] data1;
    logic [TW-1:0] typ1;
  } rvec_t;

  wvec_t load_tbl [3];
  rvec_t serve_tbl [4];
  wvec_t cap_tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input wvec_t v);
    wr_valid = 1'b1;
    wr_data  = v.data;
    wr_type  = v.typ;
    wr_last  = v.last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Single request: FETCH one cycle later, PRESENT two cycles later, then idle gap
  task automatic request_check(input string tag, input rvec_t e);
    data_request = 1'b1;
    tick();
    data_request = 1'b0;
    chk({tag, " done0 t+1"}, 64'(bus0.read_done), 64'(0));
    chk({tag, " done1 t+1"}, 64'(bus1.read_done), 64'(0));
    tick();
    chk({tag, " done0 t+2"}, 64'(bus0.read_done), 64'(e.done0));
    chk({tag, " data0"}, 64'(bus0.training_data), 64'(e.data0));
    chk({tag, " type0"}, 64'(bus0.training_data_type), 64'(e.typ0));
    chk({tag, " done1 t+2"}, 64'(bus1.read_done), 64'(e.done1));
    chk({tag, " data1"}, 64'(bus1.training_data), 64'(e.data1));
    chk({tag, " type1"}, 64'(bus1.training_data_type), 64'(e.typ1));
    tick();
    chk({tag, " done0 t+3"}, 64'(bus0.read_done), 64'(0));
    tick();
  endtask

  initial begin
    load_tbl[0] = '{32'h01010101, 2'd1, 1'b0};
    load_tbl[1] = '{32'h02020202, 2'd2, 1'b0};
    load_tbl[2] = '{32'h03030303, 2'd3, 1'b1};
    serve_tbl[0] = '{1'b1, 32'h01010101, 2'd1, 1'b1, 32'h01010101, 2'd1};
    serve_tbl[1] = '{1'b1, 32'h02020202, 2'd2, 1'b1, 32'h02020202, 2'd2};
    serve_tbl[2] = '{1'b1, 32'h03030303, 2'd3, 1'b1, 32'h03030303, 2'd3};
    serve_tbl[3] = '{1'b0, 32'h03030303, 2'd3, 1'b1, 32'h01010101, 2'd1};
    cap_tbl[0] = '{32'h10101010, 2'd0, 1'b0};
    cap_tbl[1] = '{32'h11111111, 2'd1, 1'b0};
    cap_tbl[2] = '{32'h12121212, 2'd2, 1'b0};
    cap_tbl[3] = '{32'h13131313, 2'd3, 1'b0};
    cap_tbl[4] = '{32'h14141414, 2'd0, 1'b0};

    wr_valid = 0; wr_last = 0; in_valid = 0; clear = 0; data_request = 0;
    wr_data = '0; wr_type = '0; in_data = '0;

    // Reset values
    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst read_done", 64'(bus0.read_done), 64'(0));
    chk("rst wr_ready", 64'(bus0.wr_ready), 64'(1));
    chk("rst sample_count", 64'(bus0.sample_count), 64'(0));
    chk("rst training_data", 64'(bus0.training_data), 64'(0));
    chk("rst input_data", 64'(bus0.input_data), 64'(0));
    chk("rst exhausted", 64'(bus0.exhausted), 64'(0));
    chk("rst req_overflow", 64'(bus0.req_overflow), 64'(0));
    rst = 1'b1;
    tick();

    // Load three samples and the query
    in_valid = 1'b1; in_data = 32'hAAAAAAAA;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("load wr_ready", 64'(bus0.wr_ready), 64'(1));
      write_sample(load_tbl[i]);
    end
    chk("load sample_count0", 64'(bus0.sample_count), 64'(3));
    chk("load sample_count1", 64'(bus1.sample_count), 64'(3));
    chk("load wr_ready closed", 64'(bus0.wr_ready), 64'(0));
    chk("query input_data", 64'(bus0.input_data), 64'(32'hAAAAAAAA));

    // Serve three, then exhaust (WRAP=0) / wrap (WRAP=1)
    for (int i = 0; i < 4; i++) request_check($sformatf("serve%0d", i), serve_tbl[i]);
    chk("exhausted0", 64'(bus0.exhausted), 64'(1));
    chk("exhausted1", 64'(bus1.exhausted), 64'(0));

    // clear during SERVE
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear state0", 64'(dut0.state_q), 64'(ST_IDLE));
    chk("clear sample_count", 64'(bus0.sample_count), 64'(0));
    chk("clear wr_ready", 64'(bus0.wr_ready), 64'(1));
    chk("clear input_data", 64'(bus0.input_data), 64'(32'hAAAAAAAA));
    chk("clear exhausted", 64'(bus0.exhausted), 64'(0));

    // Capacity: five writes back to back, no wr_last
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = cap_tbl[i].data; wr_type = cap_tbl[i].typ;
      chk($sformatf("cap wr_ready%0d", i), 64'(bus0.wr_ready), 64'(i < 4));
      tick();
    end
    wr_valid = 1'b0;
    chk("cap sample_count", 64'(bus0.sample_count), 64'(4));
    chk("cap state", 64'(dut0.state_q), 64'(ST_SERVE));
    for (int i = 0; i < 4; i++)
      request_check($sformatf("cap%0d", i), '{1'b1, cap_tbl[i].data, cap_tbl[i].typ,
                                              1'b1, cap_tbl[i].data, cap_tbl[i].typ});
    // Wrap on dut1 must return the first word, proving the fifth was not written
    request_check("cap wrap", '{1'b0, cap_tbl[3].data, cap_tbl[3].typ,
                                1'b1, cap_tbl[0].data, cap_tbl[0].typ});

    // Pending and overflow: requests on three consecutive cycles
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) write_sample(load_tbl[i]);
    data_request = 1'b1;
    tick();
    chk("pend done e0", 64'(bus0.read_done), 64'(0));
    tick();
    chk("pend done e1", 64'(bus0.read_done), 64'(1));
    chk("pend data e1", 64'(bus0.training_data), 64'(32'h01010101));
    tick();
    data_request = 1'b0;
    chk("pend done e2", 64'(bus0.read_done), 64'(0));
    chk("req_overflow", 64'(bus0.req_overflow), 64'(1));
    tick();
    chk("pend done e3", 64'(bus0.read_done), 64'(1));
    chk("pend data e3", 64'(bus0.training_data), 64'(32'h02020202));
    tick();
    chk("pend done e4", 64'(bus0.read_done), 64'(0));
    chk("pend state e4", 64'(dut0.state_q), 64'(ST_SERVE));

    // Reset asserted during FETCH
    data_request = 1'b1;
    tick();
    data_request = 1'b0;
    chk("pre-rst state FETCH", 64'(dut0.state_q), 64'(ST_FETCH));
    #1 rst = 1'b0;
    #1;
    chk("midrst read_done", 64'(bus0.read_done), 64'(0));
    chk("midrst sample_count", 64'(bus0.sample_count), 64'(0));
    chk("midrst training_data", 64'(bus0.training_data), 64'(0));
    chk("midrst input_data", 64'(bus0.input_data), 64'(0));
    chk("midrst req_overflow", 64'(bus0.req_overflow), 64'(0));
    chk("midrst wr_ready", 64'(bus0.wr_ready), 64'(1));
    tick();
    chk("midrst read_done held", 64'(bus0.read_done), 64'(0));
    rst = 1'b1;
    tick();
    chk("postrst read_done", 64'(bus0.read_done), 64'(0));
    chk("postrst state", 64'(dut0.state_q), 64'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
